// File: rtl/tbus_ctrl_mp_if.sv
// Shared tri-state AHB bus view for the multi-agent drive-enable controller.
// A transfer is accepted on an HCLK edge where HREADY=1 and HTRANS[1]=1; HREADY=0 holds every bus qualifier.
interface tbus_ctrl_mp_if #(
    parameter int N_AGENTS = 4
);
    logic [N_AGENTS-1:0] HGRANT;
    logic [N_AGENTS-1:0] HSEL;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic                HREADY;
    logic [N_AGENTS-1:0] MAPSn;
    logic [N_AGENTS-1:0] MDPSn;
    logic [N_AGENTS-1:0] SDPSn;
    logic [N_AGENTS-1:0] SRSn;
    logic [N_AGENTS-1:0] DENn;
    logic                STALL;
    logic                SEL_ERR;
    logic [1:0]          dbg_state;

    modport master (
        output HGRANT, HSEL, HTRANS, HWRITE, HREADY,
        input  MAPSn, MDPSn, SDPSn, SRSn, DENn, STALL, SEL_ERR, dbg_state
    );

    modport slave (
        input  HGRANT, HSEL, HTRANS, HWRITE, HREADY,
        output MAPSn, MDPSn, SDPSn, SRSn, DENn, STALL, SEL_ERR, dbg_state
    );
endinterface

// File: rtl/tbus_ctrl_mp.sv
// Drive-enable sequencer for N agents sharing one tri-state AHB bus; inserts
// STALL turnaround cycles whenever the HRWDATA driver changes.
module tbus_ctrl_mp #(
    parameter int N_AGENTS = 4,
    parameter int IDX_W    = 2,
    parameter int TURN_CYC = 1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    tbus_ctrl_mp_if.slave bus
);
    localparam int                  CNT_W    = 3;
    localparam logic [CNT_W-1:0]    TURN_LEN = CNT_W'(TURN_CYC);
    localparam logic [CNT_W-1:0]    GAP_MAX  = '1;
    localparam logic [N_AGENTS-1:0] ALL_OFF  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TURN = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_AGENTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_AGENTS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [N_AGENTS-1:0] sel_n(input logic [IDX_W-1:0] idx);
        logic [N_AGENTS-1:0] r;
        for (int i = 0; i < N_AGENTS; i++) begin
            r[i] = (IDX_W'(i) != idx);
        end
        return r;
    endfunction

    state_t              state;
    logic [IDX_W-1:0]    addr_own;
    logic [IDX_W-1:0]    drv;
    logic [IDX_W-1:0]    last_drv;
    logic                last_drv_valid;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    gap;
    logic [N_AGENTS-1:0] maps_n;
    logic [N_AGENTS-1:0] mdps_n;
    logic [N_AGENTS-1:0] sdps_n;
    logic [N_AGENTS-1:0] srs_n;
    logic [N_AGENTS-1:0] den_n;
    logic                stall;
    logic                sel_err;

    logic                rdy;
    logic                cap;
    logic                c_sv;
    logic                c_multi;
    logic                c_has_drv;
    logic                need_turn;
    logic [IDX_W-1:0]    c_own;
    logic [IDX_W-1:0]    c_slv;
    logic [IDX_W-1:0]    c_drv;
    logic [CNT_W-1:0]    idle_now;
    logic                htrans_unused;

    assign htrans_unused = bus.HTRANS[0];

    // idle_now counts undriven HRWDATA cycles up to and including the current one;
    // those already-dead cycles are credited against the turnaround.
    always_comb begin
        rdy       = bus.HREADY && (state != TURN);
        cap       = rdy && bus.HTRANS[1];
        c_own     = lowest_idx(bus.HGRANT);
        c_slv     = lowest_idx(bus.HSEL);
        c_sv      = |bus.HSEL;
        c_multi   = (bus.HSEL & (bus.HSEL - N_AGENTS'(1))) != '0;
        c_has_drv = bus.HWRITE || c_sv;
        c_drv     = bus.HWRITE ? addr_own : c_slv;
        idle_now  = '0;
        if (den_n == ALL_OFF) begin
            idle_now = (gap == GAP_MAX) ? GAP_MAX : gap + CNT_W'(1);
        end
        need_turn = c_has_drv && last_drv_valid && (c_drv != last_drv) &&
                    (idle_now < TURN_LEN);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state          <= IDLE;
            addr_own       <= '0;
            drv            <= '0;
            last_drv       <= '0;
            last_drv_valid <= 1'b0;
            cnt            <= '0;
            gap            <= '0;
            maps_n         <= sel_n('0);
            mdps_n         <= ALL_OFF;
            sdps_n         <= ALL_OFF;
            srs_n          <= ALL_OFF;
            den_n          <= ALL_OFF;
            stall          <= 1'b0;
            sel_err        <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            gap     <= idle_now;

            if (rdy && (bus.HGRANT != '0)) begin
                addr_own <= c_own;
                maps_n   <= sel_n(c_own);
            end

            case (state)
                TURN: begin
                    if (cnt <= CNT_W'(1)) begin
                        state          <= DATA;
                        stall          <= 1'b0;
                        den_n          <= sel_n(drv);
                        last_drv       <= drv;
                        last_drv_valid <= 1'b1;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (cap) begin
                        drv     <= c_drv;
                        mdps_n  <= sel_n(addr_own);
                        sdps_n  <= c_sv ? sel_n(c_slv) : ALL_OFF;
                        srs_n   <= c_sv ? sel_n(c_slv) : ALL_OFF;
                        sel_err <= c_multi;
                        if (need_turn) begin
                            state <= TURN;
                            cnt   <= TURN_LEN - idle_now;
                            stall <= 1'b1;
                            den_n <= ALL_OFF;
                        end else begin
                            state <= DATA;
                            stall <= 1'b0;
                            den_n <= c_has_drv ? sel_n(c_drv) : ALL_OFF;
                            if (c_has_drv) begin
                                last_drv       <= c_drv;
                                last_drv_valid <= 1'b1;
                            end
                        end
                    end else if (rdy) begin
                        state  <= IDLE;
                        mdps_n <= ALL_OFF;
                        sdps_n <= ALL_OFF;
                        srs_n  <= ALL_OFF;
                        den_n  <= ALL_OFF;
                    end
                end
            endcase
        end
    end

    assign bus.MAPSn     = maps_n;
    assign bus.MDPSn     = mdps_n;
    assign bus.SDPSn     = sdps_n;
    assign bus.SRSn      = srs_n;
    assign bus.DENn      = den_n;
    assign bus.STALL     = stall;
    assign bus.SEL_ERR   = sel_err;
    assign bus.dbg_state = state;
endmodule
